// File: rtl/sc_et_pkg.sv
// -----------------------------------------------------------------------------
// sc_et_pkg
// Shared definitions for early-termination stochastic-computing controllers.
// Contents:
//   sc_et_state_e  - controller FSM state encoding (IDLE, CLR, RUN, RESP)
//   clamp_prec()   - limits a requested precision k to the counter width TW
//   scale_shift()  - left shift that rescales a 2^k-cycle count to 2^TW cycles
// -----------------------------------------------------------------------------
package sc_et_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } sc_et_state_e;

   // A run of 2^k cycles cannot exceed the SNG stream length 2^tw.
   function automatic int unsigned clamp_prec(input int unsigned prec,
                                              input int unsigned tw);
      return (prec > tw) ? tw : prec;
   endfunction

   // Shift that converts a count over 2^k cycles into its 2^tw equivalent.
   function automatic int unsigned scale_shift(input int unsigned tw,
                                               input int unsigned k);
      return (k >= tw) ? 0 : (tw - k);
   endfunction

endpackage

// File: rtl/sc_et_accum.sv
// -----------------------------------------------------------------------------
// sc_et_accum
// Run-length cycle counter and ones accumulator for one SC evaluation run.
// Both are TW+1 bits wide so a full 2^TW run of ones does not wrap.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears both counters)
//   clr       - synchronous clear, has priority over en
//   en        - count this cycle: cnt += 1, ones += z
//   z         - stochastic output bit being counted
//   cnt       - cycles counted since the last clear
//   ones      - number of cycles with z=1 since the last clear
// -----------------------------------------------------------------------------
module sc_et_accum #(
   parameter int TW = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        z,
   output logic [TW:0] cnt,
   output logic [TW:0] ones
);

   logic [TW:0] cnt_q, cnt_d;
   logic [TW:0] ones_q, ones_d;

   always_comb begin
      cnt_d  = cnt_q;
      ones_d = ones_q;
      if (clr) begin
         cnt_d  = '0;
         ones_d = '0;
      end else if (en) begin
         cnt_d  = cnt_q + (TW+1)'(1);
         ones_d = ones_q + {{TW{1'b0}}, z};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         ones_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ones_q <= ones_d;
      end
   end

   assign cnt  = cnt_q;
   assign ones = ones_q;

endmodule

// File: rtl/sc_et_ctrl.sv
// -----------------------------------------------------------------------------
// sc_et_ctrl
// Early-termination controller for a stochastic number generator (SNG).
// Accepts a job (operands + precision k), clears the SNG for one cycle, runs
// it for 2^k cycles (or until the SNG reports overflow) while counting ones
// on z, then presents the count, its 2^TW-scaled equivalent and the executed
// run length.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds its payload stable while valid is 1 and ready 0.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - job request handshake; in_bx operands, in_prec k
//   sng_clr             - SNG counter clear (high in IDLE and CLR)
//   sng_bx              - operands latched at job acceptance
//   sng_done            - SNG overflow, ends a run early
//   z                   - SC circuit output bit counted during RUN
//   out_valid/out_ready - result handshake
//   out_count           - ones counted in the run
//   out_scaled          - out_count << (TW-k)
//   out_cycles          - run length actually executed
// -----------------------------------------------------------------------------
module sc_et_ctrl
   import sc_et_pkg::*;
#(
   parameter int W  = 4,
   parameter int TW = 8,
   parameter int N  = 2,
   parameter int PW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  in_bx,
   input  logic [PW-1:0]   in_prec,
   output logic            sng_clr,
   output logic [N*W-1:0]  sng_bx,
   input  logic            sng_done,
   input  logic            z,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [TW:0]     out_count,
   output logic [TW:0]     out_scaled,
   output logic [TW:0]     out_cycles
);

   sc_et_state_e   state_q, state_d;
   logic [PW-1:0]  k_q, k_d;
   logic [N*W-1:0] bx_q, bx_d;
   logic           in_ready_q, in_ready_d;
   logic           sng_clr_q, sng_clr_d;
   logic           out_valid_q, out_valid_d;

   logic [TW:0]    cnt, ones, run_last;
   logic [PW-1:0]  shift;
   logic           acc_clr, acc_en, run_end;

   assign acc_clr  = (state_q == ST_CLR);
   assign acc_en   = (state_q == ST_RUN);
   // Counter value during the final RUN cycle of a full 2^k run.
   assign run_last = ((TW+1)'(1) << k_q) - (TW+1)'(1);
   // The sng_done cycle is still counted; the run just stops after it.
   assign run_end  = acc_en && ((cnt == run_last) || sng_done);
   assign shift    = PW'(scale_shift(TW, 32'(k_q)));

   sc_et_accum #(.TW(TW)) u_accum (
      .clk  (clk),
      .rst  (rst),
      .clr  (acc_clr),
      .en   (acc_en),
      .z    (z),
      .cnt  (cnt),
      .ones (ones)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      bx_d    = bx_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               bx_d    = in_bx;
               k_d     = PW'(clamp_prec(32'(in_prec), TW));
               state_d = ST_CLR;
            end
         end
         ST_CLR:  state_d = ST_RUN;
         ST_RUN:  if (run_end) state_d = ST_RESP;
         ST_RESP: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Outputs are registered: decode them from the next state.
      in_ready_d  = (state_d == ST_IDLE);
      sng_clr_d   = (state_d == ST_IDLE) || (state_d == ST_CLR);
      out_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         bx_q        <= '0;
         in_ready_q  <= 1'b1;
         sng_clr_q   <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         bx_q        <= bx_d;
         in_ready_q  <= in_ready_d;
         sng_clr_q   <= sng_clr_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign sng_clr    = sng_clr_q;
   assign out_valid  = out_valid_q;
   assign sng_bx     = bx_q;
   // The accumulator is frozen outside RUN, so these hold through RESP.
   assign out_count  = ones;
   assign out_cycles = cnt;
   assign out_scaled = ones << shift;

endmodule

// File: tb/tb_sc_et_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sc_et_ctrl
// Self-checking bench for sc_et_ctrl (W=4, TW=8, N=2, PW=4). Each job pushes
// its expected {count, scaled, cycles} onto a queue when it is driven; the
// entry is popped and compared when out_valid is seen.
// -----------------------------------------------------------------------------
module tb_sc_et_ctrl;

   localparam int W  = 4;
   localparam int TW = 8;
   localparam int N  = 2;
   localparam int PW = 4;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [N*W-1:0]  in_bx;
   logic [PW-1:0]   in_prec;
   logic            sng_clr;
   logic [N*W-1:0]  sng_bx;
   logic            sng_done;
   logic            z;
   logic            out_valid;
   logic            out_ready;
   logic [TW:0]     out_count;
   logic [TW:0]     out_scaled;
   logic [TW:0]     out_cycles;

   logic [3*(TW+1)-1:0] exp_q[$];
   logic                zr[256];
   int                  cyc;
   int                  checks;
   int                  failures;

   sc_et_ctrl #(.W(W), .TW(TW), .N(N), .PW(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bx      (in_bx),
      .in_prec    (in_prec),
      .sng_clr    (sng_clr),
      .sng_bx     (sng_bx),
      .sng_done   (sng_done),
      .z          (z),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_scaled (out_scaled),
      .out_cycles (out_cycles)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // z pattern: 0 all ones, 1 alternating starting with 1, 2 random, 3 zeros
   function automatic logic zbit(input int mode, input int i);
      case (mode)
         0:       return 1'b1;
         1:       return (i % 2 == 0);
         2:       return zr[i % 256];
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- driver ----------------
   // Called at a negedge with the DUT idle. done_at>0 raises sng_done in RUN
   // cycle number done_at (1-based); abort_at>=0 pulses rst in RUN index
   // abort_at (0-based); hold = cycles out_ready stays low in RESP.
   task automatic run_job(input logic [N*W-1:0] bx, input int prec,
                          input int zmode, input int done_at,
                          input int abort_at, input int hold);
      int k, n, ncyc, ones, idx, waited, a;
      logic [3*(TW+1)-1:0] e;
      logic [TW:0] e_cnt, e_scl, e_cyc;
      k    = (prec > TW) ? TW : prec;
      n    = 1 << k;
      ncyc = (done_at > 0 && done_at < n) ? done_at : n;
      ones = 0;
      for (int i = 0; i < ncyc; i++) ones += int'(zbit(zmode, i));
      if (abort_at < 0)
         exp_q.push_back({(TW+1)'(ones), (TW+1)'(ones << (TW - k)),
                          (TW+1)'(ncyc)});

      check_eq("in_ready_idle", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_bx    = bx;
      in_prec  = PW'(prec);
      @(posedge clk);
      #1;
      a        = cyc;
      in_valid = 1'b0;
      in_bx    = ~bx;
      in_prec  = PW'($urandom_range(0, 15));
      @(negedge clk);
      check_eq("clr_sng_clr", 32'(sng_clr), 1);
      check_eq("clr_in_ready", 32'(in_ready), 0);
      check_eq("sng_bx_latched", 32'(sng_bx), 32'(bx));

      waited = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && waited < 600) begin
         idx = cyc - a - 1;
         if (idx == 0) check_eq("run_sng_clr", 32'(sng_clr), 0);
         z        = zbit(zmode, idx);
         sng_done = (done_at > 0 && idx == done_at - 1);
         if (idx == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst      = 1'b0;
            z        = 1'b0;
            sng_done = 1'b0;
            check_eq("abort_out_valid", 32'(out_valid), 0);
            check_eq("abort_sng_clr", 32'(sng_clr), 1);
            check_eq("abort_in_ready", 32'(in_ready), 1);
            check_eq("abort_sng_bx", 32'(sng_bx), 0);
            return;
         end
         @(negedge clk);
         waited++;
      end
      z        = 1'b0;
      sng_done = 1'b0;

      if (out_valid !== 1'b1) begin
         check_eq("out_valid_timeout", 32'(out_valid), 1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end

      check_eq("latency", 32'(cyc - a), 32'(1 + ncyc));
      if (exp_q.size() == 0) begin
         check_eq("exp_q_nonempty", 32'(exp_q.size()), 1);
         return;
      end
      e = exp_q.pop_front();
      {e_cnt, e_scl, e_cyc} = e;
      check_eq("out_count", 32'(out_count), 32'(e_cnt));
      check_eq("out_scaled", 32'(out_scaled), 32'(e_scl));
      check_eq("out_cycles", 32'(out_cycles), 32'(e_cyc));
      check_eq("resp_in_ready", 32'(in_ready), 0);
      check_eq("resp_sng_bx", 32'(sng_bx), 32'(bx));

      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_bx    = N*W'($urandom_range(0, 255));
         in_prec  = PW'($urandom_range(0, 15));
         @(negedge clk);
         check_eq("hold_out_valid", 32'(out_valid), 1);
         check_eq("hold_in_ready", 32'(in_ready), 0);
         check_eq("hold_out_count", 32'(out_count), 32'(e_cnt));
         check_eq("hold_out_scaled", 32'(out_scaled), 32'(e_scl));
         check_eq("hold_out_cycles", 32'(out_cycles), 32'(e_cyc));
         check_eq("hold_sng_bx", 32'(sng_bx), 32'(bx));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("post_out_valid", 32'(out_valid), 0);
      check_eq("post_in_ready", 32'(in_ready), 1);
      check_eq("post_sng_clr", 32'(sng_clr), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_bx     = '0;
      in_prec   = '0;
      sng_done  = 1'b0;
      z         = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 256; i++) zr[i] = 1'($urandom_range(0, 1));

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 1);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_sng_clr", 32'(sng_clr), 1);
      check_eq("rst_sng_bx", 32'(sng_bx), 0);
      check_eq("rst_out_count", 32'(out_count), 0);
      check_eq("rst_out_scaled", 32'(out_scaled), 0);
      check_eq("rst_out_cycles", 32'(out_cycles), 0);
      rst = 1'b0;
      @(negedge clk);

      run_job(8'h3c, 3, 0, 0, -1, 0);    // k=3, z=1: 8 / 256 / 8
      run_job(8'ha5, 12, 1, 0, -1, 0);   // clamp to 8, alternating: 128
      run_job(8'h71, 2, 2, 0, -1, 5);    // random z, RESP backpressure
      run_job(8'h9e, 5, 0, 0, 3, 0);     // reset in 4th RUN cycle
      run_job(8'h12, 2, 0, 0, -1, 0);    // following job: 4 cycles
      run_job(8'hc3, 8, 0, 100, -1, 0);  // sng_done cuts run at 100
      run_job(8'h0f, 0, 0, 0, -1, 0);    // k=0: 1 / 256 / 1
      run_job(8'he7, 4, 2, 0, -1, 0);    // back-to-back after handshake
      run_job(8'h5a, 8, 0, 0, -1, 2);    // full run of ones: 256, no wrap
      run_job(8'h81, 1, 3, 0, -1, 0);    // z=0 throughout

      check_eq("exp_q_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sc_et_ctrl.md
SC_ET_CTRL -- requirements
Module: sc_et_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  W  4  operand/bit-plane group width
  TW  8  total SNG counter width (stream length 2^TW)
  N  2  number of operands driven to the SNG
  PW  4  precision field width, PW >= clog2(TW+1)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  synchronous reset, active-high
  in_valid  in  1  job request
  in_ready  out  1  controller can accept a job
  in_bx  in  N x W  operand binary values
  in_prec  in  PW  requested precision k; run length 2^k cycles
  sng_clr  out  1  clears the SNG bit-plane counter, active-high (inverted at integration to the SNG's active-low reset)
  sng_bx  out  N x W  registered operands presented to the SNG
  sng_done  in  1  SNG counter overflow flag
  z  in  1  stochastic output bit of the SC circuit fed by the SNG
  out_valid  out  1  result available
  out_ready  in  1  consumer accepts result
  out_count  out  TW+1  raw number of z=1 cycles in the run
  out_scaled  out  TW+1  out_count << (TW-k), full-length equivalent
  out_cycles  out  TW+1  run length actually executed

Function
REQ-003 FSM SHALL have states IDLE, CLR, RUN, RESP.
REQ-004 IDLE: in_ready=1; in_valid&in_ready SHALL register in_bx into sng_bx and k=min(in_prec,TW), then go to CLR.
REQ-005 CLR: sng_clr=1 for exactly one cycle; cycle counter and ones accumulator SHALL clear; next state RUN.
REQ-006 RUN: sng_clr=0; each cycle accumulator += z, cycle counter += 1; after the cycle in which counter equals 2^k-1, go to RESP.
REQ-007 RUN SHALL also go to RESP if sng_done=1 in any RUN cycle, that cycle's z being counted; out_cycles then reports the true count.
REQ-008 Latency: job accepted at cycle T -> CLR at T+1 -> RUN T+2..T+1+2^k -> out_valid asserted at T+2+2^k.
REQ-009 RESP: out_valid=1; out_count, out_scaled, out_cycles stable until out_valid&out_ready, then go to IDLE.
REQ-010 in_ready SHALL be 0 in CLR, RUN, RESP; in_valid there is ignored, no state change.
REQ-011 sng_bx SHALL be stable from CLR through RESP; changes only on job acceptance.
REQ-012 in_prec > TW SHALL clamp to TW; in_prec=0 gives a one-cycle RUN.
REQ-013 Counter and accumulator are TW+1 bits; a full run of z=1 with k=TW yields out_count=2^TW without wrap.
REQ-014 out_scaled SHALL be computed from the latched k; when sng_done cut the run short it equals out_count << (TW-k) unchanged (consumer checks out_cycles).

Reset
REQ-015 rst=1 SHALL force IDLE on the next edge from any state, including mid-RUN or RESP with out_valid pending; the run is discarded.
REQ-016 Reset values: in_ready=1 (after reset cycle), out_valid=0, sng_clr=1, sng_bx=0, out_count=out_scaled=out_cycles=0, k=0.
REQ-017 sng_clr SHALL also be 1 throughout IDLE, holding the SNG at count 0.

Structure
REQ-018 A shared package SHALL hold the FSM state enum and the precision clamp/scale helpers, reusable by other early-termination controllers.
REQ-019 One sub-module is natural: sc_et_accum (cycle counter + ones accumulator with clear/enable); everything else stays in sc_et_ctrl.

Verification
REQ-020 W=4, TW=8: in_prec=3, z tied 1 -> out_valid at T+10, out_count=8, out_scaled=256, out_cycles=8.
REQ-021 in_prec=12, z alternating 1,0 -> clamped k=8, 256 RUN cycles, out_count=128, out_scaled=128.
REQ-022 out_ready held 0 for 5 cycles in RESP -> outputs stable, in_ready=0, new in_valid ignored; accept on 6th cycle, in_ready=1 next cycle.
REQ-023 rst asserted at RUN cycle 4 of k=5 job -> next cycle IDLE, out_valid=0, sng_clr=1; following job of k=2 returns out_cycles=4.
REQ-024 k=8, sng_done forced 1 at RUN cycle 100 with z=1 -> RESP, out_cycles=100, out_count=100.
REQ-025 in_prec=0, z=1 -> single RUN cycle, out_count=1, out_scaled=256, out_cycles=1; back-to-back job accepted the cycle after out handshake.
